// File: rtl/cpu_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the processor datapath.
// master = sequencer side, slave = datapath/decode side.
interface cpu_sequencer_if;
    logic [2:0]  op_class_in;
    logic        branch_taken_in;
    logic        mem_ready_in;
    logic        pc_we_out;
    logic [1:0]  pc_src_out;
    logic        ir_we_out;
    logic        reg_we_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [2:0]  state_out;
    logic        halted_out;
    logic [1:0]  fault_out;
    logic [31:0] cycle_count_out;
    logic [31:0] retired_count_out;

    modport master (
        input  op_class_in, branch_taken_in, mem_ready_in,
        output pc_we_out, pc_src_out, ir_we_out, reg_we_out, mem_re_out, mem_we_out,
               state_out, halted_out, fault_out, cycle_count_out, retired_count_out
    );

    modport slave (
        output op_class_in, branch_taken_in, mem_ready_in,
        input  pc_we_out, pc_src_out, ir_we_out, reg_we_out, mem_re_out, mem_we_out,
               state_out, halted_out, fault_out, cycle_count_out, retired_count_out
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/LATCH/EXEC/MEM/WB with wait-state
// stalls, illegal-op and memory-timeout faults, and debug counters.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LATCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    localparam logic [2:0] CL_ALU    = 3'd0;
    localparam logic [2:0] CL_LOAD   = 3'd1;
    localparam logic [2:0] CL_STORE  = 3'd2;
    localparam logic [2:0] CL_BRANCH = 3'd3;
    localparam logic [2:0] CL_JUMP   = 3'd4;
    localparam logic [2:0] CL_HALT   = 3'd5;

    // Wait count seen during the last MEM cycle allowed before a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r, state_nxt_s;
    logic [2:0]  class_r;
    logic [7:0]  wait_r;
    logic [1:0]  fault_r, fault_nxt_s;
    logic [31:0] cycle_r, retired_r;
    logic        retire_s;
    logic        pc_we_s, ir_we_s, reg_we_s, mem_re_s, mem_we_s;
    logic [1:0]  pc_src_s;

    // Next-state, fault cause, retire event and strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        fault_nxt_s = fault_r;
        retire_s    = 1'b0;
        pc_we_s     = 1'b0;
        pc_src_s    = 2'd0;
        ir_we_s     = 1'b0;
        reg_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_we_s    = 1'b0;
        case (state_r)
            ST_FETCH: state_nxt_s = ST_LATCH;
            ST_LATCH: begin
                ir_we_s     = 1'b1;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (bus.op_class_in)
                    CL_ALU:           state_nxt_s = ST_WB;
                    CL_LOAD, CL_STORE: state_nxt_s = ST_MEM;
                    CL_BRANCH: begin
                        pc_we_s     = 1'b1;
                        pc_src_s    = bus.branch_taken_in ? 2'd1 : 2'd0;
                        retire_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                    CL_JUMP: begin
                        pc_we_s     = 1'b1;
                        pc_src_s    = 2'd2;
                        retire_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                    CL_HALT: begin
                        retire_s    = 1'b1;
                        state_nxt_s = ST_HALT;
                    end
                    default: begin
                        fault_nxt_s = 2'd1;
                        state_nxt_s = ST_FAULT;
                    end
                endcase
            end
            ST_MEM: begin
                mem_re_s = (class_r == CL_LOAD);
                mem_we_s = (class_r == CL_STORE);
                // Ready takes priority over an expiring wait budget.
                if (bus.mem_ready_in) begin
                    if (class_r == CL_LOAD) begin
                        state_nxt_s = ST_WB;
                    end else begin
                        pc_we_s     = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    fault_nxt_s = 2'd2;
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_we_s    = 1'b1;
                pc_we_s     = 1'b1;
                retire_s    = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            ST_HALT:  state_nxt_s = ST_HALT;
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_FAULT;
        endcase
    end

    // State, latched class, wait counter, fault cause and debug counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            class_r   <= 3'd0;
            wait_r    <= 8'd0;
            fault_r   <= 2'd0;
            cycle_r   <= 32'd0;
            retired_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            fault_r <= fault_nxt_s;
            if (state_r == ST_EXEC) begin
                class_r <= bus.op_class_in;
                wait_r  <= 8'd0;
            end else if ((state_r == ST_MEM) && !bus.mem_ready_in) begin
                wait_r <= wait_r + 8'd1;
            end
            if ((state_r != ST_HALT) && (state_r != ST_FAULT)) begin
                cycle_r <= cycle_r + 32'd1;
            end
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    // Reset forces every output quiet at once, dropping any access in flight.
    assign bus.pc_we_out         = !reset && pc_we_s;
    assign bus.pc_src_out        = reset ? 2'd0 : pc_src_s;
    assign bus.ir_we_out         = !reset && ir_we_s;
    assign bus.reg_we_out        = !reset && reg_we_s;
    assign bus.mem_re_out        = !reset && mem_re_s;
    assign bus.mem_we_out        = !reset && mem_we_s;
    assign bus.state_out         = reset ? 3'd0 : state_r;
    assign bus.halted_out        = !reset && ((state_r == ST_HALT) || (state_r == ST_FAULT));
    assign bus.fault_out         = reset ? 2'd0 : fault_r;
    assign bus.cycle_count_out   = reset ? 32'd0 : cycle_r;
    assign bus.retired_count_out = reset ? 32'd0 : retired_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (TIMEOUT = 4).
module tb_cpu_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    cpu_sequencer_if bus_if ();

    cpu_sequencer #(.TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] op, input logic taken, input logic ready);
        bus_if.op_class_in     = op;
        bus_if.branch_taken_in = taken;
        bus_if.mem_ready_in    = ready;
        #1;
    endtask

    task automatic check_counts(input string tag, input logic [31:0] cyc, input logic [31:0] ret);
        check({tag, "_cycles"},  bus_if.cycle_count_out,   cyc);
        check({tag, "_retired"}, bus_if.retired_count_out, ret);
    endtask

    // Applies reset for one edge, checking outputs are quiet while it is held.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_pc_we"},  32'(bus_if.pc_we_out),  32'd0);
        check({tag, "_rst_mem_re"}, 32'(bus_if.mem_re_out), 32'd0);
        check({tag, "_rst_halted"}, 32'(bus_if.halted_out), 32'd0);
        check({tag, "_rst_fault"},  32'(bus_if.fault_out),  32'd0);
        check({tag, "_rst_cycles"}, bus_if.cycle_count_out, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check({tag, "_post_state"}, 32'(bus_if.state_out), 32'd0);
        check_counts({tag, "_post"}, 32'd0, 32'd0);
    endtask

    logic [2:0] ld_state  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    logic       ld_re     [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ld_ready  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ld_pc_we  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] alu_state [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [2:0] br_op     [3] = '{3'd3, 3'd3, 3'd4};
    logic       br_taken  [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0] br_src    [3] = '{2'd1, 2'd0, 2'd2};

    initial begin
        set_in(3'd0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        check("reset_state",  32'(bus_if.state_out),  32'd0);
        check("reset_ir_we",  32'(bus_if.ir_we_out),  32'd0);
        check("reset_counts", bus_if.retired_count_out, 32'd0);
        reset = 1'b0;
        #1;

        // Three ALU instructions: reg_we on cycles 4, 8, 12.
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("alu_state_c%0d", c),  32'(bus_if.state_out),  32'(alu_state[(c - 1) % 4]));
            check($sformatf("alu_reg_we_c%0d", c), 32'(bus_if.reg_we_out), 32'((c % 4) == 0));
            check($sformatf("alu_pc_we_c%0d", c),  32'(bus_if.pc_we_out),  32'((c % 4) == 0));
            tick();
        end
        check_counts("alu3", 32'd12, 32'd3);

        // LOAD with two wait cycles then ready: 7 cycles.
        for (int c = 0; c < 7; c++) begin
            set_in(3'd1, 1'b0, ld_ready[c]);
            check($sformatf("ld_state_c%0d", c),  32'(bus_if.state_out),  32'(ld_state[c]));
            check($sformatf("ld_re_c%0d", c),     32'(bus_if.mem_re_out), 32'(ld_re[c]));
            check($sformatf("ld_pc_we_c%0d", c),  32'(bus_if.pc_we_out),  32'(ld_pc_we[c]));
            check($sformatf("ld_pc_src_c%0d", c), 32'(bus_if.pc_src_out), 32'd0);
            tick();
        end
        check_counts("load", 32'd19, 32'd4);

        // Taken branch, untaken branch, jump: 3 cycles each.
        for (int i = 0; i < 3; i++) begin
            set_in(br_op[i], br_taken[i], 1'b1);
            check($sformatf("br%0d_fetch_pc_we", i), 32'(bus_if.pc_we_out), 32'd0);
            tick();
            check($sformatf("br%0d_latch_ir_we", i), 32'(bus_if.ir_we_out), 32'd1);
            tick();
            check($sformatf("br%0d_exec_state", i),  32'(bus_if.state_out),  32'd2);
            check($sformatf("br%0d_exec_pc_we", i),  32'(bus_if.pc_we_out),  32'd1);
            check($sformatf("br%0d_exec_pc_src", i), 32'(bus_if.pc_src_out), 32'(br_src[i]));
            tick();
        end
        check_counts("branch", 32'd28, 32'd7);

        // STORE with ready arriving in the 4th MEM cycle: ready beats timeout.
        set_in(3'd2, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        for (int m = 1; m <= 4; m++) begin
            set_in(3'd2, 1'b0, (m == 4));
            check($sformatf("st_ok_mem%0d_state", m), 32'(bus_if.state_out),  32'd3);
            check($sformatf("st_ok_mem%0d_we", m),    32'(bus_if.mem_we_out), 32'd1);
            check($sformatf("st_ok_mem%0d_pc_we", m), 32'(bus_if.pc_we_out),  32'(m == 4));
            tick();
        end
        check("st_ok_state", 32'(bus_if.state_out), 32'd0);
        check_counts("st_ok", 32'd35, 32'd8);

        // STORE with ready stuck low: FAULT after the 4th MEM cycle.
        set_in(3'd2, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        for (int m = 1; m <= 4; m++) begin
            check($sformatf("st_to_mem%0d_state", m), 32'(bus_if.state_out), 32'd3);
            check($sformatf("st_to_mem%0d_pc_we", m), 32'(bus_if.pc_we_out), 32'd0);
            tick();
        end
        check("st_to_state",  32'(bus_if.state_out),  32'd6);
        check("st_to_fault",  32'(bus_if.fault_out),  32'd2);
        check("st_to_halted", 32'(bus_if.halted_out), 32'd1);
        check("st_to_mem_we", 32'(bus_if.mem_we_out), 32'd0);
        check_counts("st_to", 32'd42, 32'd8);
        for (int k = 0; k < 5; k++) tick();
        check_counts("st_to_frozen", 32'd42, 32'd8);

        // Illegal class 6, then reset back to FETCH.
        do_reset("ill");
        set_in(3'd6, 1'b0, 1'b1);
        tick();
        tick();
        check("ill_exec_pc_we", 32'(bus_if.pc_we_out), 32'd0);
        tick();
        check("ill_state",  32'(bus_if.state_out),  32'd6);
        check("ill_fault",  32'(bus_if.fault_out),  32'd1);
        check("ill_halted", 32'(bus_if.halted_out), 32'd1);
        check("ill_pc_we",  32'(bus_if.pc_we_out),  32'd0);
        check_counts("ill", 32'd3, 32'd0);
        do_reset("ill_exit");

        // Two ALUs then HALT: 11 cycles, then frozen.
        set_in(3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        set_in(3'd5, 1'b0, 1'b1);
        tick();
        tick();
        check("halt_exec_pc_we", 32'(bus_if.pc_we_out), 32'd0);
        tick();
        check("halt_state",  32'(bus_if.state_out),  32'd5);
        check("halt_halted", 32'(bus_if.halted_out), 32'd1);
        check("halt_fault",  32'(bus_if.fault_out),  32'd0);
        check_counts("halt", 32'd11, 32'd3);
        for (int k = 0; k < 20; k++) tick();
        check_counts("halt_frozen", 32'd11, 32'd3);

        // Reset in the middle of a MEM wait drops the access with no retire.
        do_reset("mid");
        set_in(3'd1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("mid_mem_re", 32'(bus_if.mem_re_out), 32'd1);
        do_reset("mid_mem");
        check("mid_state", 32'(bus_if.state_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the MIPS processor datapath. It steps each instruction through fetch, IR latch, execute, memory and writeback. It generates the enable and select strobes for the PC register, IR, register file and `data_memory`. It stalls on memory/serial wait states, detects illegal instructions and memory timeouts, and keeps cycle and retired-instruction counters for debug. It sits between the `controller` decode (which supplies `op_class_in`) and the `pc`/`register`/`data_memory` instances inside `processor`.

## Interface
- `TIMEOUT`, default 255: max consecutive MEM-state cycles without `mem_ready_in` before a fault; legal range 1..255.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_class_in`  in  3  decoded class of the instruction in the IR:
  - 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT
  - 6 and 7 are illegal.
- `branch_taken_in`  in  1  ALU `Branch_out`; sampled in EXEC for class BRANCH only.
- `mem_ready_in`  in  1  `data_memory` access complete; sampled in MEM only.
- `pc_we_out`  out  1  load the PC this cycle.
- `pc_src_out`  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target; 0 whenever `pc_we_out` = 0.
- `ir_we_out`  out  1  capture the `inst_rom` output into the IR.
- `reg_we_out`  out  1  register file write enable.
- `mem_re_out`  out  1  `data_memory` `re_in`.
- `mem_we_out`  out  1  `data_memory` `we_in`.
- `state_out`  out  3  current state encoding (below).
- `halted_out`  out  1  high in HALT or FAULT.
- `fault_out`  out  2  fault cause:
  - 0 none, 1 illegal op_class, 2 memory timeout
  - held until reset.
- `cycle_count_out`  out  32  cycles spent outside HALT/FAULT.
- `retired_count_out`  out  32  instructions completed.

## Operation
- State encoding: FETCH=0, LATCH=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.
- FETCH:
  - The PC drives the `inst_rom` address. The ROM is registered, so data is valid the next cycle.
  - No strobes asserted. Next state is LATCH.
- LATCH: `ir_we_out` = 1. Next state is EXEC.
- EXEC: `op_class_in` is decoded from the IR and valid in this state.
  - ALU: next state WB.
  - LOAD or STORE: next state MEM; the wait counter clears to 0.
  - BRANCH: `pc_we_out` = 1 and `pc_src_out` = `branch_taken_in` ? 1 : 0. The instruction retires. Next state FETCH.
  - JUMP: `pc_we_out` = 1 and `pc_src_out` = 2. The instruction retires. Next state FETCH.
  - HALT: no PC write; the instruction retires. Next state HALT.
  - 6 or 7: next state FAULT with `fault_out` = 1; no retire.
- MEM: `mem_re_out` = 1 for LOAD, `mem_we_out` = 1 for STORE. The class is latched on leaving EXEC, not re-sampled.
  - `mem_ready_in` = 1, LOAD: next state WB.
  - `mem_ready_in` = 1, STORE: `pc_we_out` = 1 with `pc_src_out` = 0; the instruction retires. Next state FETCH.
  - `mem_ready_in` = 0: the wait counter (8-bit) increments. When it reaches `TIMEOUT`, next state FAULT with `fault_out` = 2. Strobes are deasserted from that next cycle.
- WB: `reg_we_out` = 1, `pc_we_out` = 1, `pc_src_out` = 0. The instruction retires. Next state FETCH.
- HALT and FAULT are absorbing: all strobes 0, counters frozen. Only `reset` exits them.
- Counters:
  - `cycle_count_out` increments on every edge whose current state is neither HALT nor FAULT.
  - `retired_count_out` increments on every retire event.
  - Both wrap modulo 2^32 with no saturation or flag.
- Strobe decode: strobes are combinational from state, latched class, and (in EXEC/MEM) `op_class_in`, `branch_taken_in`, `mem_ready_in`. No strobe is registered.

## Timing
- Reset:
  - Next edge: state = FETCH, both counters = 0, `fault_out` = 0, latched class = 0, wait counter = 0.
  - All outputs are 0 during and immediately after reset, except `state_out` = 0.
  - Reset in the middle of MEM drops the access immediately. No retire is counted and no PC write occurs.
- Latency with zero wait states:
  - ALU: 4 cycles (FETCH, LATCH, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH and JUMP: 3 cycles.
- Each MEM wait cycle adds 1 cycle. `mem_ready_in` in the first MEM cycle means zero wait.
- Timeout: with `TIMEOUT` = N and `mem_ready_in` held low, FAULT is entered on the edge ending the Nth MEM cycle. `mem_ready_in` rising in that same Nth cycle completes the access normally; ready wins over timeout.
- Exactly one `pc_we_out` pulse and one retire per completed non-HALT instruction.
- HALT retires but asserts no `pc_we_out`.

## Test plan
- ALU (class 0) repeated 3 times, `mem_ready_in` = 1:
  - `reg_we_out` pulses on cycles 4, 8, 12 after reset release.
  - `retired_count_out` = 3 and `cycle_count_out` = 12.
- LOAD with `mem_ready_in` low for 2 MEM cycles, then high:
  - `mem_re_out` is high for 3 cycles, then WB.
  - Total instruction length 7 cycles; `pc_src_out` = 0.
- BRANCH with `branch_taken_in` = 1, then BRANCH with 0, then JUMP:
  - `pc_src_out` = 1, 0, 2 on the respective EXEC cycles.
  - Each instruction is 3 cycles.
- `TIMEOUT` = 4, STORE with `mem_ready_in` stuck low:
  - FAULT entered after the 4th MEM cycle; `fault_out` = 2, `halted_out` = 1.
  - Counters freeze and `retired_count_out` is unchanged.
  - Repeat with ready in the 4th MEM cycle: the access completes normally.
- Illegal op_class 6 in EXEC: FAULT with `fault_out` = 1 and no `pc_we_out`. Then `reset` for 1 cycle: back to FETCH with counters = 0.
- Class 5 (HALT) after 2 ALUs:
  - `retired_count_out` = 3, `halted_out` = 1.
  - `cycle_count_out` stays at 11 for 20 further cycles.
